// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner: feeds one nibble per slot to an
// external combinational hex decoder, then drives the digit with dp and leading-zero blanking.

module seg_scan_digit #(
    parameter int POS = 0
) (
    input  logic [3:0] nibble,
    input  logic       upper_zero,
    input  logic       blank_lz,
    output logic       blank
);
    // Digit 0 always shows, so a value of zero still renders as "0".
    localparam logic IS_LSD = (POS == 0);

    assign blank = blank_lz & ~IS_LSD & upper_zero & (nibble == 4'h0);
endmodule

module seg_scan #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_FREQ = 1000,
    parameter int DIGITS    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  data_valid,
    input  logic                  blank_lz,
    output logic [3:0]            bin_data,
    input  logic [7:0]            seg_in,
    output logic [7:0]            seg_data,
    output logic [DIGITS-1:0]     seg_sel
);
    localparam int SCAN_CNT = CLK_FREQ / SCAN_FREQ;
    localparam int CNT_W    = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (SCAN_CNT < 3 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
        $error("seg_scan: SCAN_CNT must be >= 3 and DIGITS in 1..8");
    end

    logic [DIGITS-1:0][3:0] shadow_val;
    logic [DIGITS-1:0]      shadow_dp;
    logic [DIGITS-1:0]      blank_vec;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic                   load_pending;
    logic                   dp_q;
    logic                   blank_q;
    logic                   tick;
    logic                   load;
    // vld_pipe[0]: tick seen last cycle; vld_pipe[1]: load happened last cycle (drive now)
    logic [1:0]             vld_pipe;

    assign tick = (cnt == CNT_W'(SCAN_CNT - 1));
    assign load = load_pending | vld_pipe[0];

    // Blank decision per digit: all nibbles at and above it are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic upper_zero;
        if (k == DIGITS - 1) begin : g_top
            assign upper_zero = 1'b1;
        end else begin : g_mid
            assign upper_zero = ~|shadow_val[DIGITS-1:k+1];
        end

        seg_scan_digit #(.POS(k)) u_digit (
            .nibble     (shadow_val[k]),
            .upper_zero (upper_zero),
            .blank_lz   (blank_lz),
            .blank      (blank_vec[k])
        );
    end

    always_comb begin
        idx_nxt = idx;
        if (load_pending) begin
            idx_nxt = '0;
        end else if (idx == IDX_W'(DIGITS - 1)) begin
            idx_nxt = '0;
        end else begin
            idx_nxt = idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val   <= '0;
            shadow_dp    <= '0;
            cnt          <= '0;
            idx          <= '0;
            bin_data     <= 4'h0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b0;
            seg_sel      <= '1;
            seg_data     <= 8'hFF;
            load_pending <= 1'b1;
            vld_pipe     <= '0;
        end else begin
            // The load below reads the pre-edge shadow, so a same-edge update waits a slot.
            if (data_valid) begin
                shadow_val <= data_in;
                shadow_dp  <= dp_in;
            end

            cnt      <= tick ? '0 : cnt + 1'b1;
            vld_pipe <= {load, tick};

            if (load) begin
                load_pending <= 1'b0;
                idx          <= idx_nxt;
                bin_data     <= shadow_val[idx_nxt];
                dp_q         <= shadow_dp[idx_nxt];
                blank_q      <= blank_vec[idx_nxt];
                seg_sel      <= '1;
                seg_data     <= 8'hFF;
            end else if (vld_pipe[1]) begin
                // seg_in is the decoder's response to the nibble presented at load.
                seg_sel  <= ~(DIGITS'(1) << idx);
                seg_data <= blank_q ? 8'hFF : {~dp_q, seg_in[6:0]};
            end
        end
    end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed driver for a common-anode multi-digit 7-segment display. It sits directly around the hex-to-segment decoder.
- Holds a shadow copy of the value to display and presents one 4-bit nibble at a time to the decoder.
- Takes back the decoder's active-low segment pattern, adds decimal point and leading-zero blanking, and drives the segment and digit-select pins with anti-ghosting.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
SCAN_FREQ, 1000, digit-advance rate in Hz; SCAN_CNT = CLK_FREQ/SCAN_FREQ, must be >= 3
DIGITS, 6, number of display digits (1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
data_in  in  4*DIGITS  hex value; nibble k = digit k; digit 0 is rightmost
dp_in  in  DIGITS  decimal point enable per digit, 1 = lit
data_valid  in  1  1-cycle strobe; latch data_in/dp_in into shadow
blank_lz  in  1  1 = blank leading zeros
bin_data  out  4  nibble to decoder input
seg_in  in  8  decoder output (active-low, bit7 = dp), combinational from bin_data
seg_data  out  8  segment pins, active-low, bit7 = dp
seg_sel  out  DIGITS  digit enables, active-low, one-hot-low when driving

Behaviour:
- Reset (rst=1 at clk edge):
  - shadow value = 0, shadow dp = 0
  - cnt = 0, idx = 0, bin_data = 0
  - seg_sel = all 1s, seg_data = 8'hFF
  - load_pending = 1
- Shadow:
  - On data_valid=1, shadow <= {data_in, dp_in} at that edge.
  - Changes reach the display only at the next digit load; no mid-slot change.
  - data_valid during reset is ignored.
- Counter:
  - cnt counts 0..SCAN_CNT-1 and wraps.
  - tick = (cnt == SCAN_CNT-1).
- Load step (cycle L):
  - Occurs on the first cycle after reset release (load_pending, idx stays 0), or the cycle after a tick (idx <= idx+1, wrapping DIGITS-1 -> 0).
  - At the L edge: bin_data <= shadow nibble[idx_new].
  - Captured alongside: dp_q <= shadow dp[idx_new] and blank_q <= blank condition for idx_new.
  - Also at L: seg_sel <= all 1s and seg_data <= 8'hFF (anti-ghost gap).
- Drive step (cycle L+1):
  - seg_sel <= ~(1<<idx).
  - seg_data <= 8'hFF if blank_q; otherwise {~dp_q, seg_in[6:0]}.
  - Held until the next load step.
- Blank condition for digit k:
  - True when blank_lz=1, k>0, and shadow nibbles k..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit outputs 8'hFF even if its dp bit is set.
- Timing:
  - Slot period is SCAN_CNT cycles.
  - Each slot has exactly 1 cycle with all digits off (the L cycle), then SCAN_CNT-1 driven cycles.
  - Full refresh period is DIGITS*SCAN_CNT cycles.
- Simultaneous events:
  - data_valid on the same edge as a load step: the load uses the old shadow; the new value appears from the next slot.
  - Reset mid-slot: the next cycle is the reset state, and the display restarts at digit 0 per load_pending.
- seg_in is sampled only in the drive step. The decoder must be combinational, giving 1-cycle latency bin_data -> seg_in.

Test Plan:
- Sim params CLK_FREQ=100, SCAN_FREQ=10 (SCAN_CNT=10), DIGITS=6, real decoder attached.
  - Release reset → cycle 1: seg_sel=6'h3F, seg_data=8'hFF, bin_data=0.
  - Cycle 2: seg_sel=6'h3E, seg_data=8'hC0.
- data_valid with data_in=24'h12AB5F, dp_in=0, blank_lz=0.
  - Over one refresh, the drive steps show seg_sel 3E,3D,3B,37,2F,1F.
  - Corresponding seg_data: 8E,92,83,88,A4,F9.
  - Each slot is preceded by exactly one all-off cycle; slot period is 10 cycles.
- data_in=24'h000070, blank_lz=1.
  - Digits 0,1 show C0 and F8.
  - Digits 2..5 show FF even with dp_in=6'h3C.
  - With blank_lz=0, digits 2..5 show 40.
- dp_in=6'h04, data_in=24'h000300, blank_lz=0.
  - Digit 2 shows 8'h30 (dp lit).
  - All other digits show C0.
- data_valid asserted on a load-step edge.
  - The loaded digit shows the old value.
  - The next slot shows the new value.
  - Wrap: idx 5 → 0 occurs at tick with no skipped or doubled slot.
- Assert rst for 1 cycle mid-slot while digit 3 is driven.
  - Next cycle: seg_sel=3F, seg_data=FF, shadow cleared.
  - After release: digit 0 is driven with C0 on the 2nd cycle.
